// File: rtl/elevator_pkg.sv
// Shared floor/call types and controller state encoding for the car controller slice.
package elevator_pkg;

    localparam int unsigned NUM_FLOORS = 4;
    localparam int unsigned FLOOR_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1,
        ST_DWELL = 2'd2
    } state_e;

    typedef logic [FLOOR_W-1:0]    floor_t;
    typedef logic [NUM_FLOORS-1:0] call_vec_t;

    // One-hot call vector for a single floor.
    function automatic call_vec_t floor_mask(input floor_t f);
        return call_vec_t'(1) << f;
    endfunction

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Button/car-datapath signal bundle of the call scheduler.
interface elevator_call_scheduler_if;
    import elevator_pkg::*;

    call_vec_t call_req;
    floor_t    floor_status;
    floor_t    calling_status;
    logic      dir_up;
    logic      moving;
    logic      door_open;
    call_vec_t pending;

    modport master (
        output call_req, floor_status,
        input  calling_status, dir_up, moving, door_open, pending
    );

    modport slave (
        input  call_req, floor_status,
        output calling_status, dir_up, moving, door_open, pending
    );

endinterface

// File: rtl/elevator_call_scheduler_scan_pick.sv
// SCAN target selection: nearest pending floor ahead in the sweep, else nearest behind.
module elevator_call_scheduler_scan_pick
    import elevator_pkg::*;
(
    input  call_vec_t pending,
    input  floor_t    floor,
    input  logic      dir_up,
    output floor_t    target,
    output logic      found,
    output logic      dir_next
);

    logic   up_found;
    logic   dn_found;
    floor_t up_tgt;
    floor_t dn_tgt;

    // Lowest pending floor above and highest pending floor below the car.
    always_comb begin
        up_found = 1'b0;
        dn_found = 1'b0;
        up_tgt   = floor;
        dn_tgt   = floor;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > floor) && !up_found) begin
                up_found = 1'b1;
                up_tgt   = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) < floor)) begin
                dn_found = 1'b1;
                dn_tgt   = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        found    = 1'b0;
        target   = floor;
        dir_next = dir_up;
        if (dir_up) begin
            if (up_found) begin
                found  = 1'b1;
                target = up_tgt;
            end else if (dn_found) begin
                found    = 1'b1;
                target   = dn_tgt;
                dir_next = 1'b0;
            end
        end else begin
            if (dn_found) begin
                found  = 1'b1;
                target = dn_tgt;
            end else if (up_found) begin
                found    = 1'b1;
                target   = up_tgt;
                dir_next = 1'b1;
            end
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls, drives the SCAN target floor to the car and times the door dwell.
module elevator_call_scheduler
    import elevator_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 8,
    parameter int unsigned TIMER_W      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    elevator_call_scheduler_if.slave  bus
);

    localparam logic [TIMER_W-1:0] DWELL_LOAD = TIMER_W'(DWELL_CYCLES - 1);

    state_e             state_q,   state_d;
    call_vec_t          pending_q, pending_d;
    floor_t             calling_q, calling_d;
    logic               dir_q,     dir_d;
    logic [TIMER_W-1:0] timer_q,   timer_d;
    logic               moving_q,  moving_d;
    logic               door_q,    door_d;

    floor_t    pick_target;
    logic      pick_found;
    logic      pick_dir;
    call_vec_t here_mask;
    logic      call_here;

    elevator_call_scheduler_scan_pick u_scan_pick (
        .pending  (pending_q),
        .floor    (bus.floor_status),
        .dir_up   (dir_q),
        .target   (pick_target),
        .found    (pick_found),
        .dir_next (pick_dir)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            calling_q <= '0;
            dir_q     <= 1'b1;
            timer_q   <= '0;
            moving_q  <= 1'b0;
            door_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            calling_q <= calling_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            moving_q  <= moving_d;
            door_q    <= door_d;
        end
    end

    always_comb begin
        here_mask = floor_mask(bus.floor_status);
        call_here = |(bus.call_req & here_mask);
        state_d   = state_q;
        pending_d = pending_q | bus.call_req;
        calling_d = calling_q;
        dir_d     = dir_q;
        timer_d   = timer_q;

        case (state_q)
            ST_IDLE: begin
                // A call at the floor the car already sits on just opens the door.
                pending_d = pending_q | (bus.call_req & ~here_mask);
                calling_d = bus.floor_status;
                if (call_here) begin
                    state_d = ST_DWELL;
                    timer_d = DWELL_LOAD;
                end else if (pick_found) begin
                    state_d   = ST_MOVE;
                    calling_d = pick_target;
                    dir_d     = pick_dir;
                end
            end
            ST_MOVE: begin
                if (bus.floor_status == calling_q) begin
                    pending_d = (pending_q | bus.call_req) & ~here_mask;
                    state_d   = ST_DWELL;
                    timer_d   = DWELL_LOAD;
                end else if (pick_found && (pick_dir == dir_q)) begin
                    calling_d = pick_target;
                end
            end
            ST_DWELL: begin
                pending_d = pending_q | (bus.call_req & ~here_mask);
                calling_d = bus.floor_status;
                if (call_here) begin
                    timer_d = DWELL_LOAD;
                end else if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        moving_d = (state_d == ST_MOVE);
        door_d   = (state_d == ST_DWELL);
    end

    assign bus.calling_status = calling_q;
    assign bus.dir_up         = dir_q;
    assign bus.moving         = moving_q;
    assign bus.door_open      = door_q;
    assign bus.pending        = pending_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Bench for elevator_call_scheduler: vector table, directed corner sequences, random vs model.
module tb_elevator_call_scheduler;
    import elevator_pkg::*;

    localparam int DWELL = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    elevator_call_scheduler_if bus ();

    elevator_call_scheduler #(.DWELL_CYCLES(DWELL), .TIMER_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: 0 = idle, 1 = travelling, 2 = door open
    int m_state;
    bit m_pend [4];
    int m_cs;
    bit m_up;
    int m_timer;

    typedef struct {
        logic [3:0] call;
        int         floor;
        int         cs;
        logic [3:0] pend;
        logic       mov;
        logic       door;
        logic       up;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pend();
        int v = 0;
        for (int i = 0; i < 4; i++) if (m_pend[i]) v += (1 << i);
        return v;
    endfunction

    // Nearest pending floor strictly ahead of f in the given direction, -1 if none.
    function automatic int seek(input int f, input bit up);
        for (int d = 1; d < 4; d++) begin
            int fl = up ? f + d : f - d;
            if (fl >= 0 && fl < 4 && m_pend[fl]) return fl;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] call, input int f);
        bit np [4];
        int t;
        if (!rst) begin
            m_state = 0;
            for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
            m_cs = 0; m_up = 1'b1; m_timer = 0;
            return;
        end
        for (int i = 0; i < 4; i++) np[i] = m_pend[i] | call[i];
        case (m_state)
            0: begin
                np[f] = m_pend[f];
                m_cs  = f;
                if (call[f]) begin
                    m_state = 2; m_timer = DWELL - 1;
                end else begin
                    t = seek(f, m_up);
                    if (t < 0) begin
                        t = seek(f, !m_up);
                        if (t >= 0) m_up = !m_up;
                    end
                    if (t >= 0) begin m_state = 1; m_cs = t; end
                end
            end
            1: begin
                if (f == m_cs) begin
                    np[f] = 1'b0; m_state = 2; m_timer = DWELL - 1;
                end else begin
                    t = seek(f, m_up);
                    if (t >= 0) m_cs = t;
                end
            end
            default: begin
                np[f] = m_pend[f];
                m_cs  = f;
                if (call[f])           m_timer = DWELL - 1;
                else if (m_timer == 0) m_state = 0;
                else                   m_timer--;
            end
        endcase
        for (int i = 0; i < 4; i++) m_pend[i] = np[i];
    endtask

    task automatic check_model();
        check("calling_status", int'(bus.calling_status), m_cs);
        check("pending",        int'(bus.pending),        model_pend());
        check("dir_up",         int'(bus.dir_up),         int'(m_up));
        check("moving",         int'(bus.moving),         int'(m_state == 1));
        check("door_open",      int'(bus.door_open),      int'(m_state == 2));
    endtask

    // One clock: drive inputs, advance the model with the same inputs, compare after the edge.
    task automatic step(input logic rst, input logic [3:0] call, input int f);
        reset             = rst;
        bus.call_req      = call;
        bus.floor_status  = 2'(f);
        @(posedge clk);
        model_step(rst, call, f);
        #1;
        check_model();
    endtask

    task automatic do_reset(input int n, input int f);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, f);
    endtask

    int car;
    int door_cnt;
    logic [3:0] rc;
    logic rr;

    initial begin
        reset = 1'b0;
        bus.call_req = '0;
        bus.floor_status = '0;

        // Single call to the top floor from floor 0, full dwell then back to idle.
        tbl[0] = '{4'b1000, 0, 0, 4'b1000, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{4'b0000, 0, 3, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{4'b0000, 1, 3, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{4'b0000, 2, 3, 4'b1000, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{4'b0000, 3, 3, 4'b0000, 1'b0, 1'b1, 1'b1};
        for (int i = 5; i < 12; i++) tbl[i] = '{4'b0000, 3, 3, 4'b0000, 1'b0, 1'b1, 1'b1};
        tbl[12] = '{4'b0000, 3, 3, 4'b0000, 1'b0, 1'b0, 1'b1};

        // Reset held three cycles, then one quiet cycle.
        do_reset(3, 0);
        step(1'b1, 4'b0000, 0);
        check("t1_calling", int'(bus.calling_status), 0);
        check("t1_pending", int'(bus.pending), 0);
        check("t1_door",    int'(bus.door_open), 0);
        check("t1_moving",  int'(bus.moving), 0);

        // Vector table.
        do_reset(1, 0);
        for (int i = 0; i < 13; i++) begin
            reset = 1'b1;
            bus.call_req = tbl[i].call;
            bus.floor_status = 2'(tbl[i].floor);
            @(posedge clk);
            model_step(1'b1, tbl[i].call, tbl[i].floor);
            #1;
            check($sformatf("tbl%0d_calling", i), int'(bus.calling_status), tbl[i].cs);
            check($sformatf("tbl%0d_pending", i), int'(bus.pending), int'(tbl[i].pend));
            check($sformatf("tbl%0d_moving", i),  int'(bus.moving), int'(tbl[i].mov));
            check($sformatf("tbl%0d_door", i),    int'(bus.door_open), int'(tbl[i].door));
            check($sformatf("tbl%0d_dir", i),     int'(bus.dir_up), int'(tbl[i].up));
        end

        // Nearer call in the sweep retargets, then travel resumes to the far call.
        do_reset(1, 0);
        step(1'b1, 4'b1000, 0);
        step(1'b1, 4'b0000, 0);
        step(1'b1, 4'b0010, 0);
        step(1'b1, 4'b0000, 0);
        check("t3_retarget", int'(bus.calling_status), 1);
        step(1'b1, 4'b0000, 1);
        check("t3_stop_door", int'(bus.door_open), 1);
        check("t3_stop_pend", int'(bus.pending), 4'b1000);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 1);
        step(1'b1, 4'b0000, 1);
        check("t3_resume_cs",  int'(bus.calling_status), 3);
        check("t3_resume_mov", int'(bus.moving), 1);

        // Nothing above the car: direction flips down.
        do_reset(1, 2);
        step(1'b1, 4'b0001, 2);
        step(1'b1, 4'b0000, 2);
        check("t4_dir_flip", int'(bus.dir_up), 0);
        check("t4_target0",  int'(bus.calling_status), 0);

        // Calls on both sides while sweeping up: top first, then floor 0.
        do_reset(1, 1);
        step(1'b1, 4'b1001, 1);
        step(1'b1, 4'b0000, 1);
        check("t4_first3", int'(bus.calling_status), 3);
        step(1'b1, 4'b0000, 2);
        step(1'b1, 4'b0000, 3);
        for (int i = 0; i < 8; i++) step(1'b1, 4'b0000, 3);
        step(1'b1, 4'b0000, 3);
        check("t4_then0",   int'(bus.calling_status), 0);
        check("t4_then_dn", int'(bus.dir_up), 0);

        // Dwell reload by a same-floor call at timer 2.
        do_reset(1, 2);
        door_cnt = 0;
        step(1'b1, 4'b0100, 2);
        if (bus.door_open) door_cnt++;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0000, 2);
            if (bus.door_open) door_cnt++;
        end
        step(1'b1, 4'b0100, 2);
        if (bus.door_open) door_cnt++;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 4'b0000, 2);
            if (bus.door_open) door_cnt++;
        end
        check("t5_door_cycles", door_cnt, 14);
        check("t5_pending",     int'(bus.pending), 0);

        // Reset in the middle of a trip drops everything.
        do_reset(1, 0);
        step(1'b1, 4'b0110, 0);
        step(1'b1, 4'b0000, 0);
        check("t6_moving_pre", int'(bus.moving), 1);
        step(1'b0, 4'b0000, 0);
        check("t6_calling", int'(bus.calling_status), 0);
        check("t6_pending", int'(bus.pending), 0);
        check("t6_moving",  int'(bus.moving), 0);

        // Random calls with a car that steps one floor every third cycle toward the target.
        do_reset(1, 0);
        car = 0;
        for (int n = 0; n < 3000; n++) begin
            rc = '0;
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) rc[b] = 1'b1;
            rr = ($urandom_range(0, 499) != 0);
            if (m_state == 1 && (n % 3) == 0 && car != m_cs) car += (m_cs > car) ? 1 : -1;
            step(rr, rc, car);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
